// File: rtl/attn_score_mac_if.sv
// Host-side bundle for the attention score engine: start/config, operand matrices,
// status flags and the packed score matrix.
interface attn_score_mac_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_LEN    = 64,
    parameter int EMBED_DIM  = 64
);
    logic                                    start;
    logic                                    causal_en;
    logic [4:0]                              scale_shift;
    logic [DATA_WIDTH*SEQ_LEN*EMBED_DIM-1:0] Q_flat;
    logic [DATA_WIDTH*SEQ_LEN*EMBED_DIM-1:0] K_flat;
    logic                                    busy;
    logic                                    done;
    logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0]   scores_flat;

    modport master (
        output start, causal_en, scale_shift, Q_flat, K_flat,
        input  busy, done, scores_flat
    );

    modport slave (
        input  start, causal_en, scale_shift, Q_flat, K_flat,
        output busy, done, scores_flat
    );
endinterface

// File: rtl/attn_score_mac.sv
// Q*K^T score engine: LANES parallel fixed-point MACs per step, wide accumulator,
// runtime arithmetic scale shift, saturation to DATA_WIDTH and optional causal mask.
module attn_score_mac #(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_LEN    = 64,
    parameter int EMBED_DIM  = 64,
    parameter int LANES      = 4,
    parameter int FRAC_BITS  = 14,
    parameter int ACC_W      = 48
) (
    input  logic            clk,
    input  logic            rst_n,
    attn_score_mac_if.slave bus
);
    localparam int PW   = 2 * DATA_WIDTH;
    localparam int WIDE = (ACC_W > PW) ? ACC_W : PW;
    localparam int IW   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int KW   = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]   RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]   RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    if (EMBED_DIM % LANES != 0) begin : g_badLanes
        $error("attn_score_mac: EMBED_DIM must be a multiple of LANES");
    end
    if (ACC_W < DATA_WIDTH + $clog2(EMBED_DIM) + 1) begin : g_badAccW
        $error("attn_score_mac: ACC_W too narrow for EMBED_DIM accumulations");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_ACCUM,
        S_WRITE
    } state_t;

    state_t                         r_state;
    state_t                         w_nextState;
    logic [IW-1:0]                  r_i;
    logic [IW-1:0]                  r_j;
    logic [KW-1:0]                  r_k;
    logic signed [ACC_W-1:0]        r_accum;
    logic                           r_causal;
    logic [4:0]                     r_shift;
    logic                           r_busy;
    logic                           r_done;
    logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0] r_scores;
    logic signed [DATA_WIDTH-1:0]   r_qLane [LANES];
    logic signed [DATA_WIDTH-1:0]   r_kLane [LANES];
    logic signed [PW-1:0]           r_prod  [LANES];

    logic signed [WIDE-1:0]         w_termSum;
    logic signed [ACC_W-1:0]        w_laneSum;
    logic signed [ACC_W-1:0]        w_shifted;
    logic [DATA_WIDTH-1:0]          w_writeVal;
    logic [IW-1:0]                  w_iNext;
    logic [IW-1:0]                  w_jNext;
    logic                           w_masked;
    logic                           w_nextMasked;
    logic                           w_lastK;
    logic                           w_lastScore;

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.scores_flat = r_scores;

    assign w_masked     = r_causal && (r_j > r_i);
    assign w_nextMasked = r_causal && (w_jNext > w_iNext);
    assign w_lastK      = (r_k == KW'(EMBED_DIM - LANES));
    assign w_lastScore  = (r_i == IW'(SEQ_LEN - 1)) && (r_j == IW'(SEQ_LEN - 1));

    // Row-major walk over the score matrix: j wraps first, i advances on the wrap.
    always_comb begin
        w_jNext = (r_j == IW'(SEQ_LEN - 1)) ? '0 : r_j + IW'(1);
        w_iNext = r_i;
        if (r_j == IW'(SEQ_LEN - 1)) begin
            w_iNext = (r_i == IW'(SEQ_LEN - 1)) ? '0 : r_i + IW'(1);
        end
    end

    // Rescale every lane product back to the fixed-point grid and add the lanes together.
    always_comb begin
        w_termSum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_termSum = w_termSum + (WIDE'(r_prod[l]) >>> FRAC_BITS);
        end
        w_laneSum = w_termSum[ACC_W-1:0];
    end

    // Apply the runtime scale, clamp to the output range, and override masked positions.
    always_comb begin
        w_shifted = r_accum >>> r_shift;
        if (w_masked) begin
            w_writeVal = RES_MIN;
        end else if (w_shifted > SAT_MAX) begin
            w_writeVal = RES_MAX;
        end else if (w_shifted < SAT_MIN) begin
            w_writeVal = RES_MIN;
        end else begin
            w_writeVal = w_shifted[DATA_WIDTH-1:0];
        end
    end

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Sequencing: each unmasked score cycles LOAD/MULT/ACCUM per lane group, masked ones skip to WRITE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                // (0,0) is on the diagonal, so the first score is never masked.
                if (bus.start) begin
                    w_nextState = S_LOAD;
                end
            end
            S_LOAD:  w_nextState = S_MULT;
            S_MULT:  w_nextState = S_ACCUM;
            S_ACCUM: w_nextState = w_lastK ? S_WRITE : S_LOAD;
            S_WRITE: begin
                if (w_lastScore) begin
                    w_nextState = S_IDLE;
                end else if (w_nextMasked) begin
                    w_nextState = S_WRITE;
                end else begin
                    w_nextState = S_LOAD;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath, counters, latched configuration, status flags and the score store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_accum  <= '0;
            r_causal <= 1'b0;
            r_shift  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_scores <= '0;
            for (int l = 0; l < LANES; l++) begin
                r_qLane[l] <= '0;
                r_kLane[l] <= '0;
                r_prod[l]  <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        r_accum  <= '0;
                        r_causal <= bus.causal_en;
                        r_shift  <= bus.scale_shift;
                        r_busy   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_qLane[l] <= bus.Q_flat[(int'(r_i)*EMBED_DIM + int'(r_k) + l)*DATA_WIDTH +: DATA_WIDTH];
                        r_kLane[l] <= bus.K_flat[(int'(r_j)*EMBED_DIM + int'(r_k) + l)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                S_MULT: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_prod[l] <= PW'(r_qLane[l]) * PW'(r_kLane[l]);
                    end
                end
                S_ACCUM: begin
                    r_accum <= r_accum + w_laneSum;
                    if (!w_lastK) begin
                        r_k <= r_k + KW'(LANES);
                    end
                end
                S_WRITE: begin
                    r_scores[(int'(r_i)*SEQ_LEN + int'(r_j))*DATA_WIDTH +: DATA_WIDTH] <= w_writeVal;
                    r_k     <= '0;
                    r_accum <= '0;
                    r_i     <= w_iNext;
                    r_j     <= w_jNext;
                    if (w_lastScore) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
